// File: rtl/alu_operand_sequencer_if.sv
// Signal bundle between the operand sequencer, its switch/button panel and the downstream ALU.
// The master modport is the sequencer's view; the slave modport is the panel/ALU side.
interface alu_operand_sequencer_if #(
    parameter int N = 4
);
    logic [N-1:0] sw;
    logic [3:0]   op_sw;
    logic         btn;
    logic [N-1:0] y_in;
    logic         neg_in;
    logic         zero_in;
    logic         carry_in;
    logic [N-1:0] a_out;
    logic [N-1:0] b_out;
    logic [3:0]   op_out;
    logic [N-1:0] result;
    logic [2:0]   flags;
    logic         valid;
    logic [2:0]   state;
    logic [7:0]   op_count;

    modport master (
        input  sw, op_sw, btn, y_in, neg_in, zero_in, carry_in,
        output a_out, b_out, op_out, result, flags, valid, state, op_count
    );

    modport slave (
        output sw, op_sw, btn, y_in, neg_in, zero_in, carry_in,
        input  a_out, b_out, op_out, result, flags, valid, state, op_count
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Button-stepped sequencer that loads A, B and the opcode for an external ALU,
// then captures the ALU result and flags for display.
module alu_operand_sequencer #(
    parameter int N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    alu_operand_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic [3:0]   op_q, op_d;
    logic [2:0]   flags_q, flags_d;
    logic         valid_q, valid_d;
    logic [7:0]   count_q, count_d;

    logic         sync1_q, sync1_d, sync2_q, sync2_d, edge_q, edge_d;
    logic [1:0]   fill_q, fill_d;
    logic         armed_q, armed_d;
    logic         step;

    // fill_q marks when sync2_q holds a genuinely sampled button level after reset;
    // until the button has been seen low, a level held through reset cannot step.
    always_comb begin
        sync1_d = bus.btn;
        sync2_d = sync1_q;
        edge_d  = sync2_q;
        fill_d  = {fill_q[0], 1'b1};
        armed_d = armed_q | (fill_q[1] & ~sync2_q);
    end

    assign step = sync2_q & ~edge_q & armed_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        flags_d  = flags_q;
        valid_d  = valid_q;
        count_d  = count_q;
        case (state_q)
            S_A: begin
                if (step) begin
                    a_d     = bus.sw;
                    state_d = S_B;
                end
            end
            S_B: begin
                if (step) begin
                    b_d     = bus.sw;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (step) begin
                    op_d    = bus.op_sw;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                result_d = bus.y_in;
                flags_d  = {bus.neg_in, bus.zero_in, bus.carry_in};
                valid_d  = 1'b1;
                count_d  = count_q + 8'd1;
                state_d  = S_SHOW;
            end
            S_SHOW: begin
                if (step) begin
                    valid_d = 1'b0;
                    state_d = S_A;
                end
            end
            default: state_d = S_A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            edge_q   <= 1'b0;
            fill_q   <= 2'b00;
            armed_q  <= 1'b0;
            state_q  <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            edge_q   <= edge_d;
            fill_q   <= fill_d;
            armed_q  <= armed_d;
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign bus.a_out    = a_q;
    assign bus.b_out    = b_q;
    assign bus.op_out   = op_q;
    assign bus.result   = result_q;
    assign bus.flags    = flags_q;
    assign bus.valid    = valid_q;
    assign bus.state    = state_q;
    assign bus.op_count = count_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a small stand-in ALU on the feedback path.
module tb_alu_operand_sequencer;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;
    int   transitions;
    logic [2:0] prev_state;

    alu_operand_sequencer_if #(.N(4)) bus ();

    alu_operand_sequencer #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in ALU: 0100 add, 0101 subtract, otherwise XOR.
    // neg is the sign of the exact result, carry is carry-out (add) or borrow (subtract).
    always_comb begin
        bus.y_in     = bus.a_out ^ bus.b_out;
        bus.neg_in   = 1'b0;
        bus.carry_in = 1'b0;
        case (bus.op_out)
            4'b0100: {bus.carry_in, bus.y_in} = {1'b0, bus.a_out} + {1'b0, bus.b_out};
            4'b0101: begin
                bus.y_in     = bus.a_out - bus.b_out;
                bus.neg_in   = bus.a_out < bus.b_out;
                bus.carry_in = bus.a_out < bus.b_out;
            end
            default: ;
        endcase
        bus.zero_in = (bus.y_in == 4'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic press();
        @(negedge clk) bus.btn = 1'b1;
        repeat (3) @(negedge clk);
        bus.btn = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic full_seq(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        bus.sw = a;
        press();
        bus.sw = b;
        press();
        bus.op_sw = op;
        press();
        press();
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.btn   = 1'b0;
        bus.sw    = 4'd0;
        bus.op_sw = 4'd0;

        #12;
        check("rst state", bus.state, 0);
        check("rst a", bus.a_out, 0);
        check("rst b", bus.b_out, 0);
        check("rst op", bus.op_out, 0);
        check("rst result", bus.result, 0);
        check("rst flags", bus.flags, 0);
        check("rst valid", bus.valid, 0);
        check("rst count", bus.op_count, 0);
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);

        // Held button: step lands on the third edge, then nothing more for the rest of the hold.
        bus.sw  = 4'b0011;
        bus.btn = 1'b1;
        @(posedge clk) #1 check("held edge1 state", bus.state, 0);
        @(posedge clk) #1 check("held edge2 state", bus.state, 0);
        @(posedge clk) #1 check("held edge3 state", bus.state, 1);
        check("held a loaded", bus.a_out, 3);
        transitions = 0;
        prev_state  = bus.state;
        repeat (17) begin
            @(posedge clk) #1;
            if (bus.state != prev_state) transitions++;
            prev_state = bus.state;
        end
        check("held extra steps", transitions, 0);
        @(negedge clk) bus.btn = 1'b0;
        repeat (3) @(negedge clk);

        bus.sw = 4'b0101;
        press();
        check("load b", bus.b_out, 5);
        check("state op", bus.state, 2);

        bus.op_sw = 4'b0100;
        @(negedge clk) bus.btn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("exec state", bus.state, 3);
        check("exec no capture yet", bus.result, 0);
        check("exec valid low", bus.valid, 0);
        @(posedge clk) #1;
        check("show state", bus.state, 4);
        check("add result", bus.result, 4'b1000);
        check("add flags", bus.flags, 3'b000);
        check("add valid", bus.valid, 1);
        check("add count", bus.op_count, 1);
        check("add a", bus.a_out, 3);
        check("add b", bus.b_out, 5);
        check("add op", bus.op_out, 4'b0100);
        @(negedge clk) bus.btn = 1'b0;
        repeat (3) @(negedge clk);

        // Switch activity while showing must not disturb the captured result.
        bus.sw    = 4'hF;
        bus.op_sw = 4'hF;
        repeat (5) @(negedge clk);
        check("show holds result", bus.result, 4'b1000);
        check("show holds state", bus.state, 4);

        press();
        check("ret valid", bus.valid, 0);
        check("ret state", bus.state, 0);
        check("ret a", bus.a_out, 3);
        check("ret b", bus.b_out, 5);
        check("ret op", bus.op_out, 4'b0100);
        check("ret result", bus.result, 4'b1000);
        check("ret flags", bus.flags, 3'b000);

        bus.sw = 4'b0101;
        press();
        press();
        bus.op_sw = 4'b0101;
        press();
        check("sub zero result", bus.result, 0);
        check("sub zero flags", bus.flags, 3'b010);
        check("sub zero count", bus.op_count, 2);
        press();

        bus.sw = 4'b0011;
        press();
        bus.sw = 4'b0101;
        press();
        bus.op_sw = 4'b0101;
        press();
        check("sub neg result", bus.result, 4'b1110);
        check("sub neg bit", bus.flags[2], 1);
        check("sub neg flags", bus.flags, 3'b101);
        check("sub neg count", bus.op_count, 3);
        press();

        bus.sw = 4'd1;
        press();
        press();
        bus.op_sw = 4'b1111;
        press();
        check("op 1111 kept", bus.op_out, 4'b1111);
        check("op 1111 state", bus.state, 4);
        check("op 1111 count", bus.op_count, 4);
        press();

        for (int i = 0; i < 251; i++) full_seq(4'd3, 4'd5, 4'b0100);
        check("count 255", bus.op_count, 255);

        bus.sw = 4'd3;
        press();
        bus.sw = 4'd5;
        press();
        bus.op_sw = 4'b0100;
        press();
        check("count wrap", bus.op_count, 0);
        check("wrap result", bus.result, 4'b1000);
        press();
        full_seq(4'd3, 4'd5, 4'b0100);
        check("count after wrap", bus.op_count, 1);

        // Reset in S_OP with the button held down.
        bus.sw = 4'd3;
        press();
        bus.sw = 4'd5;
        press();
        check("pre-rst state", bus.state, 2);
        @(negedge clk) bus.btn = 1'b1;
        @(posedge clk) #2 rst = 1'b1;
        #1;
        check("arst state", bus.state, 0);
        check("arst a", bus.a_out, 0);
        check("arst b", bus.b_out, 0);
        check("arst op", bus.op_out, 0);
        check("arst result", bus.result, 0);
        check("arst flags", bus.flags, 0);
        check("arst valid", bus.valid, 0);
        check("arst count", bus.op_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("no step after release", bus.state, 0);
        check("no load after release", bus.a_out, 0);
        bus.btn = 1'b0;
        repeat (3) @(negedge clk);
        bus.sw = 4'd9;
        press();
        check("repress state", bus.state, 1);
        check("repress a", bus.a_out, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
